// File: rtl/pwm_drive_ctrl.sv
// PWM sequencer for one half-bridge phase.
// It produces complementary high/low gate commands for the downstream
// non-overlap stage. It also handles duty shadowing, a per-period soft ramp,
// coast (IDLE) and active brake.
module pwm_drive_ctrl #(
  parameter int unsigned CNT_W     = 11,
  parameter int unsigned RAMP_STEP = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             brake,
  input  logic [CNT_W-1:0] duty,
  input  logic             duty_vld,
  output logic             high_cmd,
  output logic             low_cmd,
  output logic             cycle_start,
  output logic             busy,
  output logic [CNT_W-1:0] duty_applied
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_RAMP_DN,
    S_BRAKE
  } state_t;

  localparam logic [CNT_W:0]   STEP    = (CNT_W+1)'(RAMP_STEP);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] target;
  logic [CNT_W-1:0] tgt;
  logic [CNT_W-1:0] da_ramp;
  logic [CNT_W:0]   da_ext, tgt_ext, da_up, da_dn;
  logic             active, active_nxt, boundary;

  assign active     = (state == S_RUN) || (state == S_RAMP_DN);
  assign active_nxt = (state_nxt == S_RUN) || (state_nxt == S_RAMP_DN);
  assign boundary   = active && (cnt == CNT_MAX);

  // Ramp one step toward the period target. The math is one bit wider, so it cannot wrap.
  always_comb begin
    tgt     = (state == S_RUN) ? target : '0;
    da_ext  = {1'b0, duty_applied};
    tgt_ext = {1'b0, tgt};
    da_up   = da_ext + STEP;
    da_dn   = da_ext - STEP;
    da_ramp = duty_applied;
    if (da_ext < tgt_ext) begin
      da_ramp = (da_up > tgt_ext) ? tgt : da_up[CNT_W-1:0];
    end else if (da_ext > tgt_ext) begin
      da_ramp = (da_ext < tgt_ext + STEP) ? tgt : da_dn[CNT_W-1:0];
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; brake wins in every state
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (brake)   state_nxt = S_BRAKE;
        else if (en) state_nxt = S_RUN;
      end
      S_RUN: begin
        if (brake)    state_nxt = S_BRAKE;
        else if (!en) state_nxt = S_RAMP_DN;
      end
      S_RAMP_DN: begin
        if (brake)   state_nxt = S_BRAKE;
        else if (en) state_nxt = S_RUN;
        else if (boundary && (duty_applied == '0)) state_nxt = S_IDLE;
      end
      S_BRAKE: begin
        if (!brake) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Period counter, shadow target and applied duty.
  // The counter runs only while staying in an active state. Any other
  // transition re-arms it at 0 and clears the applied duty.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt          <= '0;
      target       <= '0;
      duty_applied <= '0;
    end else begin
      if (duty_vld) target <= duty;
      if (active && active_nxt) begin
        cnt <= cnt + CNT_ONE;
        if (boundary) duty_applied <= da_ramp;
      end else begin
        cnt          <= '0;
        duty_applied <= '0;
      end
    end
  end

  // Gate commands and status decoded from the registered state and counter
  always_comb begin
    high_cmd    = 1'b0;
    low_cmd     = 1'b0;
    cycle_start = 1'b0;
    busy        = (state != S_IDLE);
    unique case (state)
      S_RUN, S_RAMP_DN: begin
        high_cmd    = (cnt < duty_applied);
        low_cmd     = ~(cnt < duty_applied);
        cycle_start = (cnt == '0);
      end
      S_BRAKE: low_cmd = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_pwm_drive_ctrl.sv
// Scoreboard bench for pwm_drive_ctrl with a 16-cycle period and a ramp step of 4.
module tb_pwm_drive_ctrl;

  localparam int unsigned CNT_W = 4;
  localparam int PER = 16;

  typedef struct packed {
    logic       h;
    logic       l;
    logic       cs;
    logic       b;
    logic [3:0] da;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst, en, brake, duty_vld;
  logic [CNT_W-1:0] duty;
  logic             high_cmd, low_cmd, cycle_start, busy;
  logic [CNT_W-1:0] duty_applied;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  pwm_drive_ctrl #(.CNT_W(CNT_W), .RAMP_STEP(4)) dut (
    .clk(clk), .rst(rst), .en(en), .brake(brake),
    .duty(duty), .duty_vld(duty_vld),
    .high_cmd(high_cmd), .low_cmd(low_cmd), .cycle_start(cycle_start),
    .busy(busy), .duty_applied(duty_applied)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t sample();
    exp_t o;
    o.h = high_cmd; o.l = low_cmd; o.cs = cycle_start; o.b = busy; o.da = duty_applied;
    return o;
  endfunction

  task automatic push_cyc(input logic h, input logic l, input logic cs, input logic b, input int da);
    exp_t e;
    e.h = h; e.l = l; e.cs = cs; e.b = b; e.da = 4'(da);
    sb.push_back(e);
  endtask

  // One running period at duty d: high for cnt < d, low otherwise
  task automatic push_period(input int d);
    for (int i = 0; i < PER; i++) push_cyc(i < d, !(i < d), i == 0, 1'b1, d);
  endtask

  task automatic test_reset();
    exp_t e, o;
    rst = 1'b1; en = 1'b0; brake = 1'b0; duty_vld = 1'b0; duty = '0;
    repeat (2) @(posedge clk);
    #1;
    push_cyc(0, 0, 0, 0, 0);
    e = sb.pop_front(); o = sample(); checks++;
    if (o !== e) begin errors++; $display("FAIL test_reset: got %p exp %p", o, e); end
    rst = 1'b0;
  endtask

  task automatic test_ramp_up();
    exp_t e, o;
    int i = 0;
    duty = 4'd10; duty_vld = 1'b1; en = 1'b1;
    tick();
    duty_vld = 1'b0;
    push_period(0); push_period(4); push_period(8); push_period(10);
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = sample(); checks++;
      if (o !== e) begin errors++; $display("FAIL test_ramp_up[%0d]: got %p exp %p", i, o, e); end
      tick(); i++;
    end
  endtask

  task automatic test_shadow();
    exp_t e, o;
    int i = 0;
    push_period(10); push_period(6); push_period(2); push_period(2);
    push_period(6); push_period(10);
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = sample(); checks++;
      if (o !== e) begin errors++; $display("FAIL test_shadow[%0d]: got %p exp %p", i, o, e); end
      if (i == 5)            begin duty = 4'd2;  duty_vld = 1'b1; end
      if (i == 6)            duty_vld = 1'b0;
      if (i == 2*PER + 15)   begin duty = 4'd10; duty_vld = 1'b1; end
      if (i == 2*PER + 16)   duty_vld = 1'b0;
      tick(); i++;
    end
  endtask

  task automatic test_ramp_down();
    exp_t e, o;
    int i = 0;
    push_period(10); push_period(6); push_period(2); push_period(0);
    push_cyc(0, 0, 0, 0, 0); push_cyc(0, 0, 0, 0, 0);
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = sample(); checks++;
      if (o !== e) begin errors++; $display("FAIL test_ramp_down[%0d]: got %p exp %p", i, o, e); end
      if (i == 0) en = 1'b0;
      tick(); i++;
    end
  endtask

  task automatic test_brake();
    exp_t e, o;
    int i = 0;
    duty = 4'd8; duty_vld = 1'b1; en = 1'b1;
    tick();
    duty_vld = 1'b0;
    push_period(0); push_period(4);
    for (int k = 0; k < 4; k++) push_cyc(1, 0, k == 0, 1, 8);
    repeat (3) push_cyc(0, 1, 0, 1, 0);
    repeat (2) push_cyc(0, 0, 0, 0, 0);
    repeat (2) push_cyc(0, 1, 0, 1, 0);
    push_cyc(0, 0, 0, 0, 0);
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = sample(); checks++;
      if (o !== e) begin errors++; $display("FAIL test_brake[%0d]: got %p exp %p", i, o, e); end
      if (i == 2*PER + 3) brake = 1'b1;
      if (i == 2*PER + 6) begin brake = 1'b0; en = 1'b0; end
      if (i == 2*PER + 8) begin brake = 1'b1; en = 1'b1; end
      if (i == 2*PER + 10) begin brake = 1'b0; en = 1'b0; end
      tick(); i++;
    end
  endtask

  task automatic test_reset_mid();
    exp_t e, o;
    int i = 0;
    en = 1'b1;
    tick();
    push_period(0); push_period(4);
    for (int k = 0; k < 8; k++) push_cyc(1, 0, k == 0, 1, 8);
    push_cyc(0, 0, 0, 0, 0);
    push_period(0); push_period(0);
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = sample(); checks++;
      if (o !== e) begin errors++; $display("FAIL test_reset_mid[%0d]: got %p exp %p", i, o, e); end
      if (i == 2*PER + 7) rst = 1'b1;
      if (i == 2*PER + 8) rst = 1'b0;
      tick(); i++;
    end
    en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_ramp_up();
    test_shadow();
    test_ramp_down();
    test_brake();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

endmodule
